// File: rtl/lc3b_types.sv
// Shared types for the split-cache CPU: line/word widths and the memory
// arbiter's state and command encodings.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        READ    = 1'b0,
        D_WRITE = 1'b1
    } arb_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one line-granular pmem port between I-cache and D-cache (ARBITER_RR_EN selects round-robin ties).
// Latency: request in IDLE at t gives a pmem command at t+1; resp forwarded combinationally.
// Backpressure: loser simply holds its request; one IDLE cycle between back-to-back grants.
import lc3b_types::*;

module mem_arbiter (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pmem_read,
    input  logic [15:0]      i_pmem_address,
    output logic [127:0]     i_pmem_rdata,
    output logic             i_pmem_resp,
    input  logic             d_pmem_read,
    input  logic             d_pmem_write,
    input  logic [15:0]      d_pmem_address,
    input  logic [127:0]     d_pmem_wdata,
    output logic [127:0]     d_pmem_rdata,
    output logic             d_pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic [127:0]     pmem_wdata,
    input  logic [127:0]     pmem_rdata,
    input  logic             pmem_resp
);

    arb_state_t state_q, state_d;
    arb_cmd_t   cmd_q, cmd_d;
    lc3b_word   addr_q, addr_d;
    lc3b_line   wdata_q, wdata_d;
    logic       i_req, d_req, grant_i, grant_d;

`ifdef ARBITER_RR_EN
    // 1 = D-cache held the most recent grant, so the next tie goes to I.
    logic last_grant_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d_q <= 1'b1;
        end else if (state_q == IDLE && (grant_i || grant_d)) begin
            last_grant_d_q <= grant_d;
        end
    end
`endif

    always_comb begin
        i_req = i_pmem_read;
        d_req = d_pmem_read | d_pmem_write;
`ifdef ARBITER_RR_EN
        grant_d = d_req & (~i_req | ~last_grant_d_q);
`else
        grant_d = d_req;
`endif
        grant_i = i_req & ~grant_d;
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = d_pmem_address;
                    wdata_d = d_pmem_wdata;
                    // Read+write together is illegal; the write wins.
                    cmd_d   = d_pmem_write ? D_WRITE : READ;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                    addr_d  = i_pmem_address;
                    cmd_d   = READ;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_read    = (state_q != IDLE) && (cmd_q == READ);
    assign pmem_write   = (state_q != IDLE) && (cmd_q == D_WRITE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = pmem_resp && (state_q == I_BUSY);
    assign d_pmem_resp  = pmem_resp && (state_q == D_BUSY);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
